// File: rtl/simon_game_ctrl.sv
// Simon Says game sequencer: shows the golden sequence, collects presses, runs the check handshake.
// Optional input timeout is enabled by defining SIMON_TIMEOUT_EN.
module simon_game_ctrl #(
    parameter logic [23:0] DISPLAY_TICKS = 24'd6_000_000,
    parameter logic [23:0] GAP_TICKS     = 24'd2_000_000,
    parameter logic [27:0] INPUT_TIMEOUT = 28'd100_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        btn_valid,
    input  logic [1:0]  btn_colour,
    input  logic [31:0] seq_mem,
    input  logic        check_done,
    input  logic        check_pass,
    output logic        en_check,
    output logic [31:0] seq_in_check,
    output logic [3:0]  round_ctr,
    output logic        led_on,
    output logic [1:0]  led_colour,
    output logic [2:0]  state_out,
    output logic        game_won,
    output logic        game_over
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SHOW_ON  = 3'd1,
        SHOW_OFF = 3'd2,
        INPUT    = 3'd3,
        CHECK    = 3'd4,
        WIN      = 3'd5,
        LOSE     = 3'd6
    } state_t;

    state_t      state;
    logic [23:0] timer;
    logic [3:0]  idx;

`ifdef SIMON_TIMEOUT_EN
    logic [27:0] to_ctr;
`else
    logic unused_timeout;
    assign unused_timeout = ^INPUT_TIMEOUT;
`endif

    assign state_out = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            timer        <= '0;
            idx          <= '0;
            en_check     <= 1'b0;
            seq_in_check <= '0;
            round_ctr    <= '0;
            led_on       <= 1'b0;
            led_colour   <= '0;
            game_won     <= 1'b0;
            game_over    <= 1'b0;
`ifdef SIMON_TIMEOUT_EN
            to_ctr       <= '0;
`endif
        end else begin
            case (state)
                IDLE, WIN, LOSE: begin
                    if (start) begin
                        state        <= SHOW_ON;
                        round_ctr    <= '0;
                        idx          <= '0;
                        seq_in_check <= '0;
                        timer        <= DISPLAY_TICKS - 24'd1;
                        led_on       <= 1'b1;
                        led_colour   <= seq_mem[1:0];
                        game_won     <= 1'b0;
                        game_over    <= 1'b0;
                    end
                end

                SHOW_ON: begin
                    if (timer == '0) begin
                        state      <= SHOW_OFF;
                        timer      <= GAP_TICKS - 24'd1;
                        led_on     <= 1'b0;
                        led_colour <= '0;
                    end else begin
                        timer <= timer - 24'd1;
                    end
                end

                SHOW_OFF: begin
                    if (timer == '0) begin
                        if (idx == round_ctr) begin
                            state        <= INPUT;
                            idx          <= '0;
                            seq_in_check <= '0;
`ifdef SIMON_TIMEOUT_EN
                            to_ctr       <= '0;
`endif
                        end else begin
                            state      <= SHOW_ON;
                            idx        <= idx + 4'd1;
                            timer      <= DISPLAY_TICKS - 24'd1;
                            led_on     <= 1'b1;
                            led_colour <= seq_mem[{idx + 4'd1, 1'b0} +: 2];
                        end
                    end else begin
                        timer <= timer - 24'd1;
                    end
                end

                INPUT: begin
                    if (btn_valid) begin
                        seq_in_check[{idx, 1'b0} +: 2] <= btn_colour;
                        if (idx == round_ctr) begin
                            state    <= CHECK;
                            en_check <= 1'b1;
                        end else begin
                            idx <= idx + 4'd1;
                        end
`ifdef SIMON_TIMEOUT_EN
                        to_ctr <= '0;
                    end else if (to_ctr == INPUT_TIMEOUT - 28'd1) begin
                        state     <= LOSE;
                        game_over <= 1'b1;
                    end else begin
                        to_ctr <= to_ctr + 28'd1;
`endif
                    end
                end

                CHECK: begin
                    // en_check high marks the first CHECK cycle; a done pulse there belongs to nothing.
                    if (en_check) begin
                        en_check <= 1'b0;
                    end else if (check_done) begin
                        if (!check_pass) begin
                            state     <= LOSE;
                            game_over <= 1'b1;
                        end else if (round_ctr == 4'd15) begin
                            state    <= WIN;
                            game_won <= 1'b1;
                        end else begin
                            state      <= SHOW_ON;
                            round_ctr  <= round_ctr + 4'd1;
                            idx        <= '0;
                            timer      <= DISPLAY_TICKS - 24'd1;
                            led_on     <= 1'b1;
                            led_colour <= seq_mem[1:0];
                        end
                    end
                end

                default: begin
                    state      <= IDLE;
                    en_check   <= 1'b0;
                    led_on     <= 1'b0;
                    led_colour <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_simon_game_ctrl.sv
// Scoreboard bench for simon_game_ctrl with DISPLAY_TICKS=4, GAP_TICKS=2, INPUT_TIMEOUT=16.
module tb_simon_game_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        btn_valid = 1'b0;
    logic [1:0]  btn_colour = 2'd0;
    logic [31:0] seq_mem = 32'd0;
    logic        check_done = 1'b0;
    logic        check_pass = 1'b0;
    logic        en_check;
    logic [31:0] seq_in_check;
    logic [3:0]  round_ctr;
    logic        led_on;
    logic [1:0]  led_colour;
    logic [2:0]  state_out;
    logic        game_won;
    logic        game_over;

    int checks = 0;
    int errors = 0;

    logic [1:0]  col_q[$];
    logic [31:0] seq_q[$];

    always #5 clk = ~clk;

    simon_game_ctrl #(
        .DISPLAY_TICKS(24'd4),
        .GAP_TICKS(24'd2),
        .INPUT_TIMEOUT(28'd16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .btn_valid(btn_valid),
        .btn_colour(btn_colour),
        .seq_mem(seq_mem),
        .check_done(check_done),
        .check_pass(check_pass),
        .en_check(en_check),
        .seq_in_check(seq_in_check),
        .round_ctr(round_ctr),
        .led_on(led_on),
        .led_colour(led_colour),
        .state_out(state_out),
        .game_won(game_won),
        .game_over(game_over)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic press(input logic [1:0] c);
        btn_valid  = 1'b1;
        btn_colour = c;
        tick();
        btn_valid  = 1'b0;
        btn_colour = 2'd0;
    endtask

    task automatic resolve(input logic pass);
        check_done = 1'b1;
        check_pass = pass;
        tick();
        check_done = 1'b0;
        check_pass = 1'b0;
    endtask

    // Queue the first n golden colours of the current seq_mem.
    task automatic push_colours(input int n);
        for (int k = 0; k < n; k++) begin
            logic [31:0] s;
            s = seq_mem >> (2 * k);
            col_q.push_back(s[1:0]);
        end
    endtask

    task automatic watch_show(input int n);
        for (int k = 0; k < n; k++) begin
            logic [1:0] exp_c;
            logic [1:0] bad_val;
            int on_cnt, off_cnt, wait_cnt, bad_col;
            if (col_q.size() == 0) begin
                errors++;
                $display("FAIL show_queue: actual empty, required a queued colour");
                return;
            end
            exp_c = col_q.pop_front();
            wait_cnt = 0;
            while (!led_on && wait_cnt < 20) begin
                tick();
                wait_cnt++;
            end
            on_cnt = 0;
            bad_col = 0;
            bad_val = 2'd0;
            while (led_on && on_cnt < 50) begin
                if (led_colour !== exp_c) begin
                    bad_col++;
                    bad_val = led_colour;
                end
                on_cnt++;
                tick();
            end
            off_cnt = 0;
            while (!led_on && state_out == 3'd2 && off_cnt < 50) begin
                if (led_colour !== 2'd0) begin
                    bad_col++;
                    bad_val = led_colour;
                end
                off_cnt++;
                tick();
            end
            checks++;
            if (on_cnt !== 4) begin
                errors++;
                $display("FAIL show_on_len[%0d]: actual %0d, required 4", k, on_cnt);
            end
            checks++;
            if (off_cnt !== 2) begin
                errors++;
                $display("FAIL show_off_len[%0d]: actual %0d, required 2", k, off_cnt);
            end
            checks++;
            if (bad_col !== 0) begin
                errors++;
                $display("FAIL show_colour[%0d]: actual %0d, required %0d lit / 0 dark", k, bad_val, exp_c);
            end
        end
        checks++;
        if (state_out !== 3'd3) begin
            errors++;
            $display("FAIL input_entry: actual state %0d, required 3", state_out);
        end
        checks++;
        if (seq_in_check !== 32'd0) begin
            errors++;
            $display("FAIL input_seq_clear: actual %h, required 0", seq_in_check);
        end
    endtask

    task automatic enter_sequence(input int n, input logic [31:0] colours);
        logic [31:0] exp_seq;
        logic [31:0] want;
        exp_seq = '0;
        for (int k = 0; k < n; k++) exp_seq[2*k +: 2] = colours[2*k +: 2];
        seq_q.push_back(exp_seq);
        for (int k = 0; k < n; k++) begin
            if (k > 0) begin
                checks++;
                if (state_out !== 3'd3) begin
                    errors++;
                    $display("FAIL mid_input[%0d]: actual state %0d, required 3", k, state_out);
                end
            end
            press(colours[2*k +: 2]);
        end
        checks++;
        if (en_check !== 1'b1) begin
            errors++;
            $display("FAIL en_check_latency: actual %b, required 1", en_check);
        end
        checks++;
        if (state_out !== 3'd4) begin
            errors++;
            $display("FAIL check_entry: actual state %0d, required 4", state_out);
        end
        want = seq_q.pop_front();
        checks++;
        if (seq_in_check !== want) begin
            errors++;
            $display("FAIL seq_in_check: actual %h, required %h", seq_in_check, want);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if ({state_out, en_check, seq_in_check, round_ctr, led_on, led_colour, game_won, game_over} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: actual state=%0d en=%b seq=%h rnd=%0d led=%b/%0d won=%b over=%b, required all 0",
                     state_out, en_check, seq_in_check, round_ctr, led_on, led_colour, game_won, game_over);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (state_out !== 3'd0) begin
            errors++;
            $display("FAIL idle_hold: actual state %0d, required 0", state_out);
        end
    endtask

    task automatic test_round0;
        int pulses;
        seq_mem = 32'h0000_001B;
        pulse_start();
        checks++;
        if (led_on !== 1'b1 || round_ctr !== 4'd0) begin
            errors++;
            $display("FAIL start_latency: actual led_on=%b round=%0d, required 1/0", led_on, round_ctr);
        end
        push_colours(1);
        watch_show(1);
        enter_sequence(1, 32'h3);
        pulses = 1;
        // done coincident with the en_check cycle must be ignored
        check_done = 1'b1;
        check_pass = 1'b1;
        tick();
        check_done = 1'b0;
        check_pass = 1'b0;
        if (en_check) pulses++;
        checks++;
        if (state_out !== 3'd4) begin
            errors++;
            $display("FAIL early_done_ignored: actual state %0d, required 4", state_out);
        end
        resolve(1'b1);
        if (en_check) pulses++;
        checks++;
        if (pulses !== 1) begin
            errors++;
            $display("FAIL en_check_pulses: actual %0d, required 1", pulses);
        end
        checks++;
        if (led_on !== 1'b1 || state_out !== 3'd1 || round_ctr !== 4'd1) begin
            errors++;
            $display("FAIL pass_advance: actual led=%b state=%0d round=%0d, required 1/1/1", led_on, state_out, round_ctr);
        end
        checks++;
        if (seq_in_check !== 32'h3) begin
            errors++;
            $display("FAIL seq_hold: actual %h, required 00000003", seq_in_check);
        end
        push_colours(2);
        watch_show(2);
    endtask

    task automatic test_round1_lose;
        enter_sequence(2, 32'h7);
        tick();
        resolve(1'b0);
        checks++;
        if (state_out !== 3'd6 || game_over !== 1'b1 || game_won !== 1'b0 || round_ctr !== 4'd1) begin
            errors++;
            $display("FAIL lose: actual state=%0d over=%b won=%b round=%0d, required 6/1/0/1", state_out, game_over, game_won, round_ctr);
        end
        pulse_start();
        checks++;
        if (round_ctr !== 4'd0 || led_on !== 1'b1 || game_over !== 1'b0 || state_out !== 3'd1) begin
            errors++;
            $display("FAIL restart: actual round=%0d led=%b over=%b state=%0d, required 0/1/0/1", round_ctr, led_on, game_over, state_out);
        end
    endtask

    task automatic test_input_wait;
        push_colours(1);
        watch_show(1);
        enter_sequence(1, 32'h3);
        tick();
        resolve(1'b1);
        push_colours(2);
        watch_show(2);
`ifdef SIMON_TIMEOUT_EN
        repeat (15) tick();
        checks++;
        if (state_out !== 3'd3) begin
            errors++;
            $display("FAIL timeout_early: actual state %0d, required 3", state_out);
        end
        press(2'd0);
        checks++;
        if (state_out !== 3'd3) begin
            errors++;
            $display("FAIL timeout_press_priority: actual state %0d, required 3", state_out);
        end
        repeat (15) tick();
        checks++;
        if (state_out !== 3'd3) begin
            errors++;
            $display("FAIL timeout_restart: actual state %0d, required 3", state_out);
        end
        tick();
        checks++;
        if (state_out !== 3'd6 || game_over !== 1'b1 || round_ctr !== 4'd1) begin
            errors++;
            $display("FAIL timeout_lose: actual state=%0d over=%b round=%0d, required 6/1/1", state_out, game_over, round_ctr);
        end
`else
        repeat (40) tick();
        checks++;
        if (state_out !== 3'd3) begin
            errors++;
            $display("FAIL input_waits: actual state %0d, required 3", state_out);
        end
        pulse_start();
        checks++;
        if (state_out !== 3'd3 || round_ctr !== 4'd1 || led_on !== 1'b0) begin
            errors++;
            $display("FAIL start_ignored: actual state=%0d round=%0d led=%b, required 3/1/0", state_out, round_ctr, led_on);
        end
        enter_sequence(2, 32'h6);
        tick();
        resolve(1'b0);
        checks++;
        if (state_out !== 3'd6 || game_over !== 1'b1) begin
            errors++;
            $display("FAIL lose_round1: actual state=%0d over=%b, required 6/1", state_out, game_over);
        end
`endif
    endtask

    task automatic test_win;
        seq_mem = $urandom;
        pulse_start();
        for (int r = 0; r < 16; r++) begin
            push_colours(r + 1);
            watch_show(r + 1);
            checks++;
            if (round_ctr !== r[3:0]) begin
                errors++;
                $display("FAIL round_ctr[%0d]: actual %0d, required %0d", r, round_ctr, r);
            end
            enter_sequence(r + 1, seq_mem);
            tick();
            resolve(1'b1);
        end
        checks++;
        if (state_out !== 3'd5 || game_won !== 1'b1 || game_over !== 1'b0 || round_ctr !== 4'd15 || led_on !== 1'b0) begin
            errors++;
            $display("FAIL win: actual state=%0d won=%b over=%b round=%0d led=%b, required 5/1/0/15/0",
                     state_out, game_won, game_over, round_ctr, led_on);
        end
        press(2'd2);
        resolve(1'b1);
        resolve(1'b0);
        tick();
        checks++;
        if (state_out !== 3'd5 || game_won !== 1'b1 || round_ctr !== 4'd15 || seq_in_check !== seq_mem || en_check !== 1'b0) begin
            errors++;
            $display("FAIL win_hold: actual state=%0d won=%b round=%0d seq=%h en=%b, required 5/1/15/%h/0",
                     state_out, game_won, round_ctr, seq_in_check, en_check, seq_mem);
        end
    endtask

    task automatic test_reset_mid;
        pulse_start();
        tick();
        rst = 1'b1;
        #1;
        checks++;
        if ({state_out, en_check, seq_in_check, round_ctr, led_on, led_colour, game_won, game_over} !== '0) begin
            errors++;
            $display("FAIL reset_show_on: actual state=%0d led=%b/%0d won=%b, required all 0", state_out, led_on, led_colour, game_won);
        end
        rst = 1'b0;
        tick();
        pulse_start();
        push_colours(1);
        watch_show(1);
        enter_sequence(1, 32'h1);
        rst = 1'b1;
        #1;
        checks++;
        if ({state_out, en_check, seq_in_check, round_ctr, led_on, led_colour, game_won, game_over} !== '0) begin
            errors++;
            $display("FAIL reset_check: actual state=%0d en=%b seq=%h, required all 0", state_out, en_check, seq_in_check);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (state_out !== 3'd0 || en_check !== 1'b0) begin
            errors++;
            $display("FAIL reset_drop_en: actual state=%0d en=%b, required 0/0", state_out, en_check);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_round0();
        test_round1_lose();
        test_input_wait();
        test_win();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
